puf_host_requester: RTL and testbench

- Initiator (host) side of the PUF UART link.
- Sends the ID byte, checks the ID echo, sends one challenge byte, then collects a fixed number of response bytes and presents them on a byte stream.
- Used as the on-chip verifier/loopback driver in front of a UART tx/rx pair, and as the traffic generator in board-level self-test.

---
 rtl/puf_link_pkg.sv | 20 ++
 rtl/puf_host_requester_if.sv | 31 +++
 rtl/link_timeout_counter.sv | 38 +++
 rtl/puf_host_requester.sv | 166 ++++++++++++++++
 tb/tb_puf_host_requester.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/puf_link_pkg.sv
// Shared types and constants for the PUF UART link.
// Used by both the host requester and the device-side responder.
package puf_link_pkg;

   localparam int unsigned LINK_BITS = 8;
   localparam logic [7:0]  DEFAULT_ID = 8'b10101010;

   typedef enum logic [2:0] {
      IDLE,
      SEND_ID,
      WAIT_ECHO,
      SEND_CHAL,
      RECV_RESP
   } link_state_t;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_ID      = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/puf_host_requester_if.sv
// UART-side signal bundle of the PUF link.
// master = requester FSM, slave = UART tx/rx pair.
interface puf_host_requester_if;
   import puf_link_pkg::*;

   logic                 tx_busy;
   logic                 tx_enable;
   logic [LINK_BITS-1:0] tx_data;
   logic                 rx_enable;
   logic                 valid_data_in;
   logic [LINK_BITS-1:0] rx_data_in;

   modport master (
      input  tx_busy,
      input  valid_data_in,
      input  rx_data_in,
      output tx_enable,
      output tx_data,
      output rx_enable
   );

   modport slave (
      output tx_busy,
      output valid_data_in,
      output rx_data_in,
      input  tx_enable,
      input  tx_data,
      input  rx_enable
   );

endinterface

// File: rtl/link_timeout_counter.sv
// Idle-cycle watchdog: counts while run is high, cleared by load,
// flags expiry on the cycle the count sits at TIMEOUT_CYCLES-1.
module link_timeout_counter #(
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic run,
   output logic expired
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign expired = run && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = '0;
      end else if (run && !expired) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/puf_host_requester.sv
// Host side of the PUF UART link: sends ID, checks echo, sends the
// challenge and streams back a fixed number of response bytes.
module puf_host_requester
   import puf_link_pkg::*;
#(
   parameter int unsigned DATA_IN_BITS   = 8,
   parameter logic [7:0]  ID             = DEFAULT_ID,
   parameter int unsigned N_RESP         = 4,
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [DATA_IN_BITS-1:0] challenge_in,
   puf_host_requester_if.master    uart,
   output logic [DATA_IN_BITS-1:0] resp_data,
   output logic                    resp_valid,
   output logic [7:0]              resp_idx,
   output logic                    busy,
   output logic                    done,
   output logic                    error,
   output logic [1:0]              err_code
);

   localparam logic [7:0] LAST_IDX = 8'(N_RESP - 1);

   link_state_t state_q, state_d;
   logic [DATA_IN_BITS-1:0] chal_q, chal_d;
   logic [DATA_IN_BITS-1:0] tx_data_q, tx_data_d;
   logic [DATA_IN_BITS-1:0] resp_data_q, resp_data_d;
   logic [7:0] resp_idx_q, resp_idx_d;
   logic [7:0] cnt_q, cnt_d;
   logic [1:0] err_q, err_d;
   logic tx_en_q, tx_en_d;
   logic resp_valid_q, resp_valid_d;
   logic done_q, done_d;
   logic error_q, error_d;

   logic rx_phase;
   logic tmo_load;
   logic tmo_expired;

   assign rx_phase = (state_q == WAIT_ECHO) || (state_q == RECV_RESP);
   // Reload outside receive states so each wait starts from zero.
   assign tmo_load = !rx_phase || uart.valid_data_in;

   link_timeout_counter #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_tmo (
      .clk    (clk),
      .reset  (reset),
      .load   (tmo_load),
      .run    (rx_phase),
      .expired(tmo_expired)
   );

   always_comb begin
      state_d      = state_q;
      chal_d       = chal_q;
      tx_en_d      = 1'b0;
      tx_data_d    = tx_data_q;
      resp_valid_d = 1'b0;
      resp_data_d  = resp_data_q;
      resp_idx_d   = resp_idx_q;
      cnt_d        = cnt_q;
      done_d       = 1'b0;
      error_d      = 1'b0;
      err_d        = err_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               chal_d  = challenge_in;
               err_d   = ERR_NONE;
               cnt_d   = '0;
               state_d = SEND_ID;
            end
         end
         SEND_ID: begin
            if (!uart.tx_busy) begin
               tx_en_d   = 1'b1;
               tx_data_d = ID;
               state_d   = WAIT_ECHO;
            end
         end
         WAIT_ECHO: begin
            if (uart.valid_data_in) begin
               if (uart.rx_data_in == ID) begin
                  state_d = SEND_CHAL;
               end else begin
                  err_d   = ERR_ID;
                  error_d = 1'b1;
                  state_d = IDLE;
               end
            end else if (tmo_expired) begin
               err_d   = ERR_TIMEOUT;
               error_d = 1'b1;
               state_d = IDLE;
            end
         end
         SEND_CHAL: begin
            if (!uart.tx_busy) begin
               tx_en_d   = 1'b1;
               tx_data_d = chal_q;
               state_d   = RECV_RESP;
            end
         end
         RECV_RESP: begin
            if (uart.valid_data_in) begin
               resp_valid_d = 1'b1;
               resp_data_d  = uart.rx_data_in;
               resp_idx_d   = cnt_q;
               cnt_d        = cnt_q + 8'd1;
               if (cnt_q == LAST_IDX) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end else if (tmo_expired) begin
               err_d   = ERR_TIMEOUT;
               error_d = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         chal_q       <= '0;
         tx_en_q      <= 1'b0;
         tx_data_q    <= '0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         resp_idx_q   <= '0;
         cnt_q        <= '0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         err_q        <= ERR_NONE;
      end else begin
         state_q      <= state_d;
         chal_q       <= chal_d;
         tx_en_q      <= tx_en_d;
         tx_data_q    <= tx_data_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         resp_idx_q   <= resp_idx_d;
         cnt_q        <= cnt_d;
         done_q       <= done_d;
         error_q      <= error_d;
         err_q        <= err_d;
      end
   end

   assign uart.tx_enable = tx_en_q;
   assign uart.tx_data   = tx_data_q;
   assign uart.rx_enable = rx_phase;
   assign resp_data      = resp_data_q;
   assign resp_valid     = resp_valid_q;
   assign resp_idx       = resp_idx_q;
   assign busy           = (state_q != IDLE);
   assign done           = done_q;
   assign error          = error_q;
   assign err_code       = err_q;

endmodule

// File: tb/tb_puf_host_requester.sv
// Randomised bench for puf_host_requester with a transaction-level
// reference model and directed scenarios.
`timescale 1ns/1ps
module tb_puf_host_requester;
   import puf_link_pkg::*;

   localparam int unsigned T  = 16;
   localparam int unsigned NR = 4;
   localparam logic [7:0] IDB = 8'hAA;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic start = 1'b0;
   logic [7:0] challenge_in = 8'h00;
   logic [7:0] resp_data;
   logic [7:0] resp_idx;
   logic resp_valid, busy, done, error;
   logic [1:0] err_code;

   puf_host_requester_if uart();

   always #5 clk = ~clk;

   puf_host_requester #(
      .DATA_IN_BITS(8), .ID(IDB), .N_RESP(NR), .TIMEOUT_CYCLES(T)
   ) dut (
      .clk(clk), .reset(reset), .start(start),
      .challenge_in(challenge_in), .uart(uart),
      .resp_data(resp_data), .resp_valid(resp_valid),
      .resp_idx(resp_idx), .busy(busy), .done(done),
      .error(error), .err_code(err_code)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 30)
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Transaction-level model: phase 0 idle, 1 id to send,
   // 2 awaiting echo, 3 challenge to send, 4 collecting responses.
   int m_phase = 0;
   int m_silent = 0;
   int m_count = 0;
   logic [7:0] m_chal = 0;
   logic [1:0] m_err = 0;
   logic e_tx_en = 0, e_rv = 0, e_done = 0, e_err = 0;
   logic [7:0] e_tx_data = 0, e_rd = 0, e_ri = 0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_phase <= 0; m_silent <= 0; m_count <= 0;
         m_chal <= 0; m_err <= 0;
         e_tx_en <= 0; e_tx_data <= 0; e_rv <= 0;
         e_rd <= 0; e_ri <= 0; e_done <= 0; e_err <= 0;
      end else begin
         e_tx_en <= 0; e_rv <= 0; e_done <= 0; e_err <= 0;
         case (m_phase)
            0: if (start) begin
               m_chal <= challenge_in; m_err <= 0;
               m_count <= 0; m_phase <= 1;
            end
            1, 3: if (!uart.tx_busy) begin
               e_tx_en <= 1;
               e_tx_data <= (m_phase == 1) ? IDB : m_chal;
               m_phase <= m_phase + 1;
               m_silent <= 0;
            end
            2, 4: begin
               if (uart.valid_data_in) begin
                  m_silent <= 0;
                  if (m_phase == 2) begin
                     if (uart.rx_data_in == IDB) m_phase <= 3;
                     else begin
                        m_err <= 1; e_err <= 1; m_phase <= 0;
                     end
                  end else begin
                     e_rv <= 1; e_rd <= uart.rx_data_in;
                     e_ri <= 8'(m_count);
                     m_count <= m_count + 1;
                     if (m_count + 1 == NR) begin
                        e_done <= 1; m_phase <= 0;
                     end
                  end
               end else if (m_silent + 1 == T) begin
                  m_err <= 2; e_err <= 1; m_phase <= 0;
               end else begin
                  m_silent <= m_silent + 1;
               end
            end
            default: ;
         endcase
      end
   end

   logic [7:0] txq[$];
   int txc[$];
   logic [7:0] rdq[$];
   logic [7:0] riq[$];
   int done_cnt = 0, err_cnt = 0, err_cyc = 0, r1_cyc = 0;
   logic [7:0] done_idx = 0;
   logic done_vld = 0;
   logic prev_tx = 0;

   always @(negedge clk) begin
      if (chk_en) begin
         chk("tx_enable", uart.tx_enable, e_tx_en);
         chk("tx_data", uart.tx_data, e_tx_data);
         chk("rx_enable", uart.rx_enable,
             (m_phase == 2) || (m_phase == 4));
         chk("busy", busy, m_phase != 0);
         chk("resp_valid", resp_valid, e_rv);
         chk("resp_data", resp_data, e_rd);
         chk("resp_idx", resp_idx, e_ri);
         chk("done", done, e_done);
         chk("error", error, e_err);
         chk("err_code", err_code, m_err);
         chk("tx_while_busy", uart.tx_enable & uart.tx_busy, 0);
         chk("tx_back_to_back", uart.tx_enable & prev_tx, 0);
         chk("done_with_error", done & error, 0);
      end
      prev_tx = uart.tx_enable;
      if (uart.tx_enable) begin
         txq.push_back(uart.tx_data); txc.push_back(cyc);
      end
      if (resp_valid) begin
         rdq.push_back(resp_data); riq.push_back(resp_idx);
         if (resp_idx == 8'd1) r1_cyc = cyc;
      end
      if (done) begin
         done_cnt++; done_idx = resp_idx; done_vld = resp_valid;
      end
      if (error) begin
         err_cnt++; err_cyc = cyc;
      end
   end

   function automatic logic [7:0] q8(input logic [7:0] q[$], input int i);
      return (i < q.size()) ? q[i] : 8'hxx;
   endfunction

   task automatic clear_logs();
      txq.delete(); txc.delete(); rdq.delete(); riq.delete();
      done_cnt = 0; err_cnt = 0; done_idx = 0; done_vld = 0;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   int st_cyc = 0, rel_cyc = 0, tx_before = 0;

   task automatic wait_tx(output bit ok);
      ok = 0;
      for (int k = 0; k < 300; k++) begin
         tick();
         if (uart.tx_enable) begin ok = 1; return; end
         if (!busy) return;
      end
      chk("wait_tx_bound", 1, 0);
   endtask

   task automatic uart_busy_after_tx();
      tick();
      uart.tx_busy = 1'b1;
      repeat ($urandom_range(3, 1)) tick();
      uart.tx_busy = 1'b0;
   endtask

   task automatic send(input logic [7:0] b);
      uart.valid_data_in = 1'b1; uart.rx_data_in = b;
      tick();
      uart.valid_data_in = 1'b0;
   endtask

   task automatic settle();
      for (int k = 0; k < 80; k++) begin
         tick();
         if (!busy) begin tick(); return; end
      end
      chk("settle_bound", 1, 0);
   endtask

   task automatic run_txn(input logic [7:0] chal, input logic [7:0] echo,
                          input int nbytes, input logic [7:0] base,
                          input int glo, input int ghi, input int pre_busy,
                          input bit extra_start, input int rst_after);
      bit ok;
      logic [7:0] b;
      start = 1'b1; challenge_in = chal; st_cyc = cyc;
      tick();
      start = 1'b0;
      if (pre_busy > 0) begin
         uart.tx_busy = 1'b1;
         repeat (pre_busy) tick();
         uart.tx_busy = 1'b0;
      end
      rel_cyc = cyc; tx_before = txq.size();
      wait_tx(ok);
      if (!ok) return;
      uart_busy_after_tx();
      repeat ($urandom_range(ghi, glo)) tick();
      send(echo);
      if (echo != IDB) begin settle(); return; end
      wait_tx(ok);
      if (!ok) return;
      uart_busy_after_tx();
      for (int i = 0; i < nbytes; i++) begin
         repeat ($urandom_range(ghi, glo)) tick();
         if (i == rst_after) begin
            reset = 1'b0; #1;
            chk("reset_outputs_zero",
                {uart.tx_enable, uart.tx_data, uart.rx_enable, resp_valid,
                 resp_data, resp_idx, busy, done, error, err_code}, 0);
            tick();
            reset = 1'b1;
            return;
         end
         if (extra_start && i == 1 && busy) begin
            start = 1'b1; challenge_in = 8'hFF;
            tick();
            start = 1'b0;
         end
         b = base + 8'(17 * (i + 1));
         send(b);
      end
      settle();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      uart.tx_busy = 1'b0;
      uart.valid_data_in = 1'b0;
      uart.rx_data_in = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk_en = 1'b1;
      chk("reset_state",
          {uart.tx_enable, uart.tx_data, uart.rx_enable, resp_valid,
           resp_data, resp_idx, busy, done, error, err_code}, 0);
      reset = 1'b1;
      tick(); tick();

      // nominal transaction
      clear_logs();
      run_txn(8'h3C, IDB, 4, 8'h00, 2, 2, 0, 0, -1);
      chk("nom_tx_count", txq.size(), 2);
      chk("nom_tx_bytes", {q8(txq, 0), q8(txq, 1)}, 16'hAA3C);
      chk("nom_latency", (txc.size() > 0) ? txc[0] - st_cyc : -1, 2);
      chk("nom_resp_data", {q8(rdq, 0), q8(rdq, 1), q8(rdq, 2),
                            q8(rdq, 3)}, 32'h11223344);
      chk("nom_resp_idx", {q8(riq, 0), q8(riq, 1), q8(riq, 2),
                           q8(riq, 3)}, 32'h00010203);
      chk("nom_done", {done_cnt[7:0], done_idx, 7'd0, done_vld},
          {8'd1, 8'd3, 8'd1});
      chk("nom_err_code", {err_cnt[7:0], err_code}, {8'd0, ERR_NONE});

      // wrong echo
      clear_logs();
      run_txn(8'h5A, 8'h55, 4, 8'h00, 1, 1, 0, 0, -1);
      chk("echo_tx_count", txq.size(), 1);
      chk("echo_err", {err_cnt[7:0], done_cnt[7:0], err_code},
          {8'd1, 8'd0, ERR_ID});

      // timeout after two of four bytes
      clear_logs();
      run_txn(8'h77, IDB, 2, 8'h00, 1, 1, 0, 0, -1);
      chk("tmo_err", {err_cnt[7:0], done_cnt[7:0], err_code},
          {8'd1, 8'd0, ERR_TIMEOUT});
      chk("tmo_delay", err_cyc - r1_cyc, 16);

      // extra start during responses, then back-to-back start
      clear_logs();
      run_txn(8'h96, IDB, 4, 8'h20, 1, 2, 0, 1, -1);
      chk("xstart_tx_count", txq.size(), 2);
      chk("xstart_done", {done_cnt[7:0], err_code}, {8'd1, ERR_NONE});
      clear_logs();
      run_txn(8'h0F, IDB, 4, 8'h40, 0, 1, 0, 0, -1);
      chk("again_done", {done_cnt[7:0], err_cnt[7:0]}, {8'd1, 8'd0});

      // tx_busy held for 50 cycles after start
      clear_logs();
      run_txn(8'hC3, IDB, 4, 8'h00, 1, 3, 50, 0, -1);
      chk("busy_no_early_tx", tx_before, 0);
      chk("busy_tx_release", (txc.size() > 0) ? txc[0] - rel_cyc : -1, 1);
      chk("busy_done", done_cnt, 1);

      // reset in the middle of the response phase
      clear_logs();
      run_txn(8'h12, IDB, 4, 8'h00, 1, 1, 0, 0, 1);
      chk("rst_no_pulse", {done_cnt[7:0], err_cnt[7:0]}, 0);
      tick();
      clear_logs();
      run_txn(8'h3C, IDB, 4, 8'h00, 1, 2, 0, 0, -1);
      chk("post_rst_done", {done_cnt[7:0], q8(rdq, 3)}, {8'd1, 8'h44});

      // randomised traffic
      for (int n = 0; n < 40; n++) begin
         logic [7:0] ch, ec;
         ch = 8'($urandom);
         ec = ($urandom_range(5, 0) == 0) ? 8'($urandom) : IDB;
         run_txn(ch, ec, ($urandom_range(3, 0) == 0) ? NR - 1 : NR,
                 8'($urandom), 0,
                 ($urandom_range(7, 0) == 0) ? 20 : 12,
                 $urandom_range(4, 0), 1'($urandom), -1);
         repeat ($urandom_range(3, 0)) tick();
         if ($urandom_range(2, 0) == 0) send(8'($urandom));
      end
      repeat (4) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
